ifetch_wide: RTL and testbench

Parametrised multi-wide instruction fetch stage with a decoupling fetch queue. It sits between the branch/ROB redirect sources and the icache on one side and decode on the other. Each cycle it selects the next PC by fixed priority and drives the icache address. It enqueues up to `FETCH_WIDTH` instructions from each 64-bit icache response. Decode drains the queue with a ready handshake, so fetch keeps running while decode stalls, and the queue is flushed on non-speculative redirects.

---
 rtl/ifetch_wide.sv | 203 ++++++++++++++++++++
 tb/tb_ifetch_wide.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_wide.sv
// ifetch_wide: multi-wide instruction fetch stage with a decoupling fetch queue.
// Selects the next PC (certain > rob > pred > sequential), drives the icache
// address, enqueues up to FETCH_WIDTH instructions per response, and lets decode
// drain the queue with a ready handshake. certain/rob redirects flush the queue.
// Optional feature: define IFETCH_PERF_EN to add saturating perf counter ports.
module ifetch_wide #(
    parameter int unsigned      XLEN        = 32,
    parameter int unsigned      FETCH_WIDTH = 2,
    parameter int unsigned      FQ_DEPTH    = 8,
    parameter logic [XLEN-1:0]  RESET_PC    = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          if_valid,
    input  logic [XLEN-1:0]               certain_branch_pc,
    input  logic                          certain_branch_req,
    input  logic [XLEN-1:0]               rob_target_pc,
    input  logic                          rob_target_req,
    input  logic [XLEN-1:0]               branch_pred_pc,
    input  logic                          branch_pred_req,
    input  logic [63:0]                   Icache2proc_data,
    input  logic                          Icache2proc_data_valid,
    output logic [XLEN-1:0]               proc2Icache_addr,
    input  logic                          deq_ready,
    output logic [FETCH_WIDTH-1:0]        out_valid,
    output logic [32*FETCH_WIDTH-1:0]     out_inst,
    output logic [XLEN*FETCH_WIDTH-1:0]   out_pc,
    output logic [$clog2(FQ_DEPTH):0]     fq_count,
    output logic [3:0]                    gnt_debug,
    output logic [XLEN-1:0]               PC_reg_debug
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]                   perf_fetched,
    output logic [31:0]                   perf_full_stalls
`endif
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {S_FETCH, S_SETTLE} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, tail_p1;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       fq_inst_q [FQ_DEPTH];
    logic [31:0]       fq_inst_d [FQ_DEPTH];
    logic [XLEN-1:0]   fq_pc_q   [FQ_DEPTH];
    logic [XLEN-1:0]   fq_pc_d   [FQ_DEPTH];

    logic              redirect, flush, resp_ok, fits, full_stall;
    logic [XLEN-1:0]   redirect_pc, seq_pc, pc_aligned, wpc0, wpc1;
    logic [31:0]       word0, word1;
    logic [CNT_W-1:0]  n_inst, free_slots, enq_n, deq_n;

    assign pc_aligned       = {pc_q[XLEN-1:3], 3'b000};
    assign proc2Icache_addr = pc_aligned;
    assign PC_reg_debug     = pc_q;
    assign fq_count         = count_q;

    // Split the 64-bit icache block into program-ordered instruction slots
    always_comb begin
        word0 = pc_q[2] ? Icache2proc_data[63:32] : Icache2proc_data[31:0];
        word1 = Icache2proc_data[63:32];
        wpc0  = pc_q;
        wpc1  = pc_q + XLEN'(4);
        if (FETCH_WIDTH == 2) begin
            n_inst = pc_q[2] ? CNT_W'(1) : CNT_W'(2);
            seq_pc = pc_aligned + XLEN'(8);
        end else begin
            n_inst = CNT_W'(1);
            seq_pc = pc_q + XLEN'(4);
        end
    end

    // PC source arbitration, enqueue/dequeue sizing and one-hot grant
    always_comb begin
        redirect    = if_valid & (certain_branch_req | rob_target_req | branch_pred_req);
        flush       = if_valid & (certain_branch_req | rob_target_req);
        redirect_pc = certain_branch_req ? certain_branch_pc :
                      rob_target_req     ? rob_target_pc     : branch_pred_pc;
        free_slots  = CNT_W'(FQ_DEPTH) - count_q;
        fits        = free_slots >= n_inst;
        resp_ok     = if_valid && !redirect && (state_q == S_FETCH) && Icache2proc_data_valid;
        enq_n       = (resp_ok && fits) ? n_inst : '0;
        full_stall  = resp_ok && !fits;
        if (!deq_ready)
            deq_n = '0;
        else if (count_q > CNT_W'(FETCH_WIDTH))
            deq_n = CNT_W'(FETCH_WIDTH);
        else
            deq_n = count_q;
        gnt_debug = '0;
        if (!reset && if_valid) begin
            if (certain_branch_req)   gnt_debug = 4'b0001;
            else if (rob_target_req)  gnt_debug = 4'b0010;
            else if (branch_pred_req) gnt_debug = 4'b0100;
            else if (enq_n != '0)     gnt_debug = 4'b1000;
        end
    end

    // Next PC and fetch/settle state
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            state_d = S_SETTLE;
        end else if (if_valid) begin
            state_d = S_FETCH;
            if (enq_n != '0) pc_d = seq_pc;
        end
    end

    // Queue storage writes, pointer and occupancy update
    always_comb begin
        tail_p1   = tail_q + PTR_W'(1);
        fq_inst_d = fq_inst_q;
        fq_pc_d   = fq_pc_q;
        if (enq_n != '0) begin
            fq_inst_d[tail_q] = word0;
            fq_pc_d[tail_q]   = wpc0;
        end
        if (enq_n == CNT_W'(2)) begin
            fq_inst_d[tail_p1] = word1;
            fq_pc_d[tail_p1]   = wpc1;
        end
        head_d  = head_q + PTR_W'(deq_n);
        tail_d  = tail_q + PTR_W'(enq_n);
        count_d = count_q + enq_n - deq_n;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Output lanes are combinational reads starting at the queue head
    always_comb begin
        out_valid = '0;
        out_inst  = '0;
        out_pc    = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            out_valid[i]           = count_q > CNT_W'(i);
            out_inst[32*i +: 32]   = fq_inst_q[head_q + PTR_W'(i)];
            out_pc[XLEN*i +: XLEN] = fq_pc_q[head_q + PTR_W'(i)];
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue payload storage; validity is tracked by count, so no reset needed
    always_ff @(posedge clock) begin
        fq_inst_q <= fq_inst_d;
        fq_pc_q   <= fq_pc_d;
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic [32:0] fetched_sum;

    // Saturating counters for enqueued instructions and queue-full drops
    always_comb begin
        fetched_sum    = {1'b0, perf_fetched_q} + 33'(enq_n);
        perf_fetched_d = fetched_sum[32] ? '1 : fetched_sum[31:0];
        perf_stalls_d  = perf_stalls_q;
        if (full_stall && (perf_stalls_q != '1))
            perf_stalls_d = perf_stalls_q + 32'd1;
    end

    // Perf counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stalls_q  <= perf_stalls_d;
        end
    end

    assign perf_fetched     = perf_fetched_q;
    assign perf_full_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_ifetch_wide.sv
// Directed, table-driven bench for ifetch_wide (FETCH_WIDTH=2, FQ_DEPTH=8).
module tb_ifetch_wide;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] certain_branch_pc, rob_target_pc, branch_pred_pc;
    logic        certain_branch_req, rob_target_req, branch_pred_req;
    logic [63:0] Icache2proc_data;
    logic        Icache2proc_data_valid;
    logic [31:0] proc2Icache_addr;
    logic        deq_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_inst;
    logic [63:0] out_pc;
    logic [3:0]  fq_count;
    logic [3:0]  gnt_debug;
    logic [31:0] PC_reg_debug;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_full_stalls;
`endif

    always #5 clock = ~clock;

    ifetch_wide #(
        .XLEN(32), .FETCH_WIDTH(2), .FQ_DEPTH(8), .RESET_PC(32'h0)
    ) dut (
        .clock(clock), .reset(reset), .if_valid(if_valid),
        .certain_branch_pc(certain_branch_pc), .certain_branch_req(certain_branch_req),
        .rob_target_pc(rob_target_pc), .rob_target_req(rob_target_req),
        .branch_pred_pc(branch_pred_pc), .branch_pred_req(branch_pred_req),
        .Icache2proc_data(Icache2proc_data), .Icache2proc_data_valid(Icache2proc_data_valid),
        .proc2Icache_addr(proc2Icache_addr), .deq_ready(deq_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .fq_count(fq_count), .gnt_debug(gnt_debug), .PC_reg_debug(PC_reg_debug)
`ifdef IFETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_full_stalls(perf_full_stalls)
`endif
    );

    typedef struct {
        bit          ifv;
        bit          cr;  logic [31:0] ct;
        bit          rr;  logic [31:0] rt;
        bit          pr;  logic [31:0] pt;
        bit          hit;
        bit          dr;
        logic [3:0]  gnt;
        int          cnt;
        logic [31:0] pc;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] prev_pc  = 32'h0;
    vec_t        vq[$];
    vec_t        pre[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic vec_t mk(input bit ifv, input bit cr, input logic [31:0] ct,
                                input bit rr, input logic [31:0] rt,
                                input bit pr, input logic [31:0] pt,
                                input bit hit, input bit dr, input logic [3:0] gnt,
                                input int cnt, input logic [31:0] pc,
                                input logic [31:0] pc0, input logic [31:0] pc1);
        vec_t v;
        v.ifv = ifv; v.cr = cr; v.ct = ct; v.rr = rr; v.rt = rt; v.pr = pr; v.pt = pt;
        v.hit = hit; v.dr = dr; v.gnt = gnt; v.cnt = cnt; v.pc = pc; v.pc0 = pc0; v.pc1 = pc1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        logic [31:0] blk;
        blk = {prev_pc[31:3], 3'b000};
        if_valid               = v.ifv;
        certain_branch_req     = v.cr;  certain_branch_pc = v.ct;
        rob_target_req         = v.rr;  rob_target_pc     = v.rt;
        branch_pred_req        = v.pr;  branch_pred_pc    = v.pt;
        deq_ready              = v.dr;
        Icache2proc_data_valid = v.hit;
        Icache2proc_data       = v.hit ? {inst_of(blk + 32'd4), inst_of(blk)} : 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [1:0] ev;
        drive(v);
        #1;
        chk({tag, "_gnt"}, 64'(gnt_debug), 64'(v.gnt));
        @(posedge clock);
        #1;
        ev = {v.cnt > 1, v.cnt > 0};
        chk({tag, "_count"}, 64'(fq_count), 64'(v.cnt));
        chk({tag, "_pc"}, 64'(PC_reg_debug), 64'(v.pc));
        chk({tag, "_addr"}, 64'(proc2Icache_addr), 64'({v.pc[31:3], 3'b000}));
        chk({tag, "_valid"}, 64'(out_valid), 64'(ev));
        if (v.cnt > 0) begin
            chk({tag, "_pc0"}, 64'(out_pc[31:0]), 64'(v.pc0));
            chk({tag, "_inst0"}, 64'(out_inst[31:0]), 64'(inst_of(v.pc0)));
        end
        if (v.cnt > 1) begin
            chk({tag, "_pc1"}, 64'(out_pc[63:32]), 64'(v.pc1));
            chk({tag, "_inst1"}, 64'(out_inst[63:32]), 64'(inst_of(v.pc1)));
        end
        prev_pc = v.pc;
    endtask

    initial begin
        // Sequence leading to 3 queued entries before a mid-fetch reset
        pre.push_back(mk(1,0,0,0,0,0,0,         1,0, 4'b1000, 2, 32'h8,  32'h0, 32'h4));
        pre.push_back(mk(1,0,0,0,0,1,32'h14,    0,0, 4'b0100, 2, 32'h14, 32'h0, 32'h4));
        pre.push_back(mk(1,0,0,0,0,0,0,         1,0, 4'b0000, 2, 32'h14, 32'h0, 32'h4));
        pre.push_back(mk(1,0,0,0,0,0,0,         1,0, 4'b1000, 3, 32'h18, 32'h0, 32'h4));

        // Main table: ifv,cr,ct,rr,rt,pr,pt,hit,dr | gnt,cnt,pc,lane0 pc,lane1 pc
        vq.push_back(mk(1,1,32'h1000,0,0,0,0,   1,0, 4'b0001, 0, 32'h1000, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b0000, 0, 32'h1000, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 2, 32'h1008, 32'h1000, 32'h1004));
        vq.push_back(mk(1,1,32'h1004,0,0,0,0,   1,0, 4'b0001, 0, 32'h1004, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b0000, 0, 32'h1004, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 1, 32'h1008, 32'h1004, 0));
        vq.push_back(mk(1,1,32'h1000,0,0,0,0,   1,0, 4'b0001, 0, 32'h1000, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b0000, 0, 32'h1000, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 2, 32'h1008, 32'h1000, 32'h1004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 4, 32'h1010, 32'h1000, 32'h1004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 6, 32'h1018, 32'h1000, 32'h1004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 8, 32'h1020, 32'h1000, 32'h1004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b0000, 8, 32'h1020, 32'h1000, 32'h1004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b0000, 8, 32'h1020, 32'h1000, 32'h1004));
        vq.push_back(mk(1,0,0,0,0,0,0,          0,1, 4'b0000, 6, 32'h1020, 32'h1008, 32'h100C));
        vq.push_back(mk(1,0,0,0,0,0,0,          0,1, 4'b0000, 4, 32'h1020, 32'h1010, 32'h1014));
        vq.push_back(mk(1,0,0,0,0,0,0,          0,1, 4'b0000, 2, 32'h1020, 32'h1018, 32'h101C));
        vq.push_back(mk(1,0,0,0,0,0,0,          0,1, 4'b0000, 0, 32'h1020, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,1, 4'b1000, 2, 32'h1028, 32'h1020, 32'h1024));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,1, 4'b1000, 2, 32'h1030, 32'h1028, 32'h102C));
        vq.push_back(mk(1,0,0,0,0,1,32'h500C,   0,0, 4'b0100, 2, 32'h500C, 32'h1028, 32'h102C));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b0000, 2, 32'h500C, 32'h1028, 32'h102C));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 3, 32'h5010, 32'h1028, 32'h102C));
        vq.push_back(mk(0,1,32'h7000,0,0,0,0,   1,1, 4'b0000, 1, 32'h5010, 32'h500C, 0));
        vq.push_back(mk(1,0,0,1,32'h4000,1,32'h6000, 1,1, 4'b0010, 0, 32'h4000, 0, 0));
        vq.push_back(mk(1,1,32'h1110,1,32'h2220,1,32'h3330, 1,0, 4'b0001, 0, 32'h1110, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b0000, 0, 32'h1110, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 2, 32'h1118, 32'h1110, 32'h1114));
        vq.push_back(mk(1,0,0,1,32'h2224,0,0,   1,1, 4'b0010, 0, 32'h2224, 0, 0));
        vq.push_back(mk(1,1,32'h3000,0,0,0,0,   1,0, 4'b0001, 0, 32'h3000, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b0000, 0, 32'h3000, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 2, 32'h3008, 32'h3000, 32'h3004));
        vq.push_back(mk(0,0,0,0,0,0,0,          1,0, 4'b0000, 2, 32'h3008, 32'h3000, 32'h3004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 4, 32'h3010, 32'h3000, 32'h3004));
        vq.push_back(mk(1,0,0,0,0,1,32'h3014,   0,0, 4'b0100, 4, 32'h3014, 32'h3000, 32'h3004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b0000, 4, 32'h3014, 32'h3000, 32'h3004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 5, 32'h3018, 32'h3000, 32'h3004));
        vq.push_back(mk(1,0,0,1,32'h4000,0,0,   1,1, 4'b0010, 0, 32'h4000, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,1, 4'b0000, 0, 32'h4000, 0, 0));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,1, 4'b1000, 2, 32'h4008, 32'h4000, 32'h4004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 4, 32'h4010, 32'h4000, 32'h4004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 6, 32'h4018, 32'h4000, 32'h4004));
        vq.push_back(mk(1,0,0,0,0,1,32'h401C,   0,0, 4'b0100, 6, 32'h401C, 32'h4000, 32'h4004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b0000, 6, 32'h401C, 32'h4000, 32'h4004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b1000, 7, 32'h4020, 32'h4000, 32'h4004));
        vq.push_back(mk(1,0,0,0,0,0,0,          1,0, 4'b0000, 7, 32'h4020, 32'h4000, 32'h4004));

        // Power-on reset
        reset = 1'b1;
        drive(mk(0,0,0,0,0,0,0, 0,0, 4'b0000, 0, 0, 0, 0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("por_count", 64'(fq_count), 64'd0);
        chk("por_valid", 64'(out_valid), 64'd0);
        chk("por_pc", 64'(PC_reg_debug), 64'h0);
        chk("por_addr", 64'(proc2Icache_addr), 64'h0);
`ifdef IFETCH_PERF_EN
        chk("por_perf_fetched", 64'(perf_fetched), 64'd0);
`endif

        foreach (pre[i]) run_vec(pre[i], $sformatf("pre%0d", i));

        // Asynchronous reset mid-fetch with a valid response still presented
        drive(mk(1,0,0,0,0,0,0, 1,0, 4'b0000, 0, 0, 0, 0));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 64'(fq_count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_pc", 64'(PC_reg_debug), 64'h0);
        chk("arst_gnt", 64'(gnt_debug), 64'h0);
        chk("arst_addr", 64'(proc2Icache_addr), 64'h0);
        @(posedge clock);
        #1;
        reset   = 1'b0;
        prev_pc = 32'h0;
        chk("arst_hold_count", 64'(fq_count), 64'd0);

        for (int i = 0; i < vq.size(); i++) run_vec(vq[i], $sformatf("v%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
